// File: rtl/xifo_rd_stream_if.sv
// Output stream of the xifo read drain: valid/ready handshake plus data.
// master = word producer (the drain stage), slave = downstream consumer.
interface xifo_rd_stream_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0] Dout_data;
    logic            Dout_valid;
    logic            Dout_ready;

    modport master (
        output Dout_data,
        output Dout_valid,
        input  Dout_ready
    );

    modport slave (
        input  Dout_data,
        input  Dout_valid,
        output Dout_ready
    );
endinterface

// File: rtl/xifo_rd_stream.sv
// xifo_rd_stream: read-side drain stage behind the stack/queue buffer.
// Issues Rden while words are available and the 2-entry skid buffer has room
// (counting the word already in flight), captures the 1-cycle-latency RAM
// data and presents it on a valid/ready stream at full throughput.
// Optional macro XIFO_RD_CNT_EN adds the Rd_count delivered-word counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing buffered, nothing in flight
// ACTIVE | words buffered and/or one read in flight
// FLUSH  | one cycle after a Flush that caught a word in flight
module xifo_rd_stream #(
    parameter int SIZE      = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic              Rdclk,
    input  logic              Rst,
    input  logic              Empty,
    input  logic [SIZE-1:0]   Dataout,
    output logic              Rden,
    input  logic              Flush,
    xifo_rd_stream_if.master  dout,
    output logic              Busy
`ifdef XIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] Rd_count
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [1:0]      occ;
    logic [1:0]      occ_nxt;
    logic            inflight;
    logic [SIZE-1:0] skid0;
    logic [SIZE-1:0] skid1;
    logic            pop;
    logic            capture;
    logic            wr_slot0;
    logic [2:0]      level;

    assign dout.Dout_valid = (occ != 2'd0);
    assign dout.Dout_data  = skid0;
    assign Busy            = (state != ST_IDLE);

    assign pop     = dout.Dout_valid & dout.Dout_ready;
    assign capture = inflight & ~Flush;

    // Room check counts the word already in flight and the slot freed by a
    // same-cycle pop, so the skid buffer can never be overrun.
    assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign Rden  = ~Rst & ~Flush & ~Empty & (state != ST_FLUSH) & (level < 3'd2);

    // A captured word lands behind whatever survives this cycle's pop.
    assign wr_slot0 = (occ == 2'd0) || ((occ == 2'd1) && pop);

    // Next skid occupancy: Flush empties it, otherwise +capture -pop.
    always_comb begin
        occ_nxt = occ;
        if (Flush) begin
            occ_nxt = 2'd0;
        end else begin
            occ_nxt = occ + {1'b0, capture} - {1'b0, pop};
        end
    end

    // Next FSM state; "becomes idle" looks at next-cycle occ and inflight.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Rden) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (Flush) begin
                    state_nxt = inflight ? ST_FLUSH : ST_IDLE;
                end else if ((occ_nxt == 2'd0) && !Rden) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                state_nxt = Flush ? ST_FLUSH : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control registers: FSM, occupancy and the read-in-flight marker.
    always_ff @(posedge Rdclk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            occ      <= occ_nxt;
            inflight <= Rden;
        end
    end

    // Skid storage: shift on pop, write the in-flight word behind the head.
    always_ff @(posedge Rdclk) begin
        if (Rst) begin
            skid0 <= '0;
            skid1 <= '0;
        end else if (!Flush) begin
            if (pop) skid0 <= skid1;
            if (capture) begin
                if (wr_slot0) skid0 <= Dataout;
                else          skid1 <= Dataout;
            end
        end
    end

`ifdef XIFO_RD_CNT_EN
    // Delivered-word counter; survives Flush, cleared only by reset.
    always_ff @(posedge Rdclk) begin
        if (Rst) begin
            Rd_count <= '0;
        end else if (pop) begin
            Rd_count <= Rd_count + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    // Simulation-only invariants: no skid overflow, no read of an empty buffer.
    always_ff @(posedge Rdclk) begin
        if (!Rst) begin
            assert (SIZE >= 8 && SIZE <= 32 && CNT_WIDTH >= 1);
            assert (occ <= 2'd2);
            assert (!(Rden && Empty));
            assert ((state != ST_IDLE) || ((occ == 2'd0) && !inflight));
        end
    end
`endif

endmodule

// File: tb/tb_xifo_rd_stream.sv
// Directed bench for xifo_rd_stream. The upstream buffer is a queue model:
// a Rden seen before an edge pops one word onto Dataout after that edge.
// Inputs change at posedge+1, outputs are sampled at the following negedge.
module tb_xifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic       rden;
    logic       flush;
    logic [7:0] dataout;
    logic       busy;
`ifdef XIFO_RD_CNT_EN
    logic [3:0] rd_count;
`endif

    always #5 clk = ~clk;

    xifo_rd_stream_if #(.SIZE(8)) dout ();

    xifo_rd_stream #(.SIZE(8), .CNT_WIDTH(4)) dut (
        .Rdclk   (clk),
        .Rst     (rst),
        .Empty   (empty),
        .Dataout (dataout),
        .Rden    (rden),
        .Flush   (flush),
        .dout    (dout),
        .Busy    (busy)
`ifdef XIFO_RD_CNT_EN
        ,
        .Rd_count(rd_count)
`endif
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] up_q[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic       empty_force = 1'b0;
    logic       rden_s = 1'b0;
    int         pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rden_s && up_q.size() > 0) dataout = up_q.pop_front();
    endtask

    task automatic settle();
        empty = empty_force || (up_q.size() == 0);
        #4;
        rden_s = rden;
        chk("no_underflow", 32'(rden & empty), 32'd0);
        if (dout.Dout_valid && dout.Dout_ready && !rst) got.push_back(dout.Dout_data);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            settle();
        end
    endtask

    task automatic compare_got(input string tag);
        chk({tag, "_n"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) chk(tag, 32'(got[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        // Reset held two cycles with words available upstream
        rst = 1'b1;
        flush = 1'b0;
        dataout = 8'h00;
        dout.Dout_ready = 1'b1;
        up_q = '{8'h11, 8'h22, 8'h33};
        settle();
        chk("rst_rden_a", 32'(rden), 32'd0);
        tick(); settle();
        chk("rst_rden_b", 32'(rden), 32'd0);
        chk("rst_valid_b", 32'(dout.Dout_valid), 32'd0);

        // Streaming: release reset straight into three back-to-back reads
        tick(); rst = 1'b0; settle();
        chk("rst_valid", 32'(dout.Dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(dout.Dout_data), 32'd0);
`ifdef XIFO_RD_CNT_EN
        chk("rst_count", 32'(rd_count), 32'd0);
`endif
        chk("strm_rden0", 32'(rden), 32'd1);
        tick(); settle();
        chk("strm_rden1", 32'(rden), 32'd1);
        chk("strm_valid1", 32'(dout.Dout_valid), 32'd0);
        tick(); settle();
        chk("strm_rden2", 32'(rden), 32'd1);
        chk("strm_data_11", 32'(dout.Dout_data), 32'h11);
        tick(); settle();
        chk("strm_rden3", 32'(rden), 32'd0);
        chk("strm_data_22", 32'(dout.Dout_data), 32'h22);
        tick(); settle();
        chk("strm_data_33", 32'(dout.Dout_data), 32'h33);
        tick(); settle();
        chk("strm_valid_end", 32'(dout.Dout_valid), 32'd0);
        chk("strm_busy_end", 32'(busy), 32'd0);
`ifdef XIFO_RD_CNT_EN
        chk("strm_count", 32'(rd_count), 32'd3);
`endif
        exp_q = '{8'h11, 8'h22, 8'h33};
        compare_got("strm_order");

        // Back-pressure: 5 words, consumer stalled
        got.delete();
        up_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        dout.Dout_ready = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); settle();
            pulses += int'(rden);
            if (i >= 3) chk("bp_hold_data", 32'(dout.Dout_data), 32'h11);
        end
        chk("bp_rden_pulses", 32'(pulses), 32'd2);
        chk("bp_valid", 32'(dout.Dout_valid), 32'd1);
        chk("bp_occ", 32'(dut.occ), 32'd2);
        for (int i = 0; i < 8; i++) begin
            tick(); dout.Dout_ready = 1'b1; settle();
        end
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        compare_got("bp_order");
        chk("bp_busy_end", 32'(busy), 32'd0);

        // Flush catching the A5 read in flight; 5A must still come through
        got.delete();
        up_q = '{8'hA5, 8'h5A};
        tick(); settle();
        chk("fl_rden_n", 32'(rden), 32'd1);
        tick(); flush = 1'b1; settle();
        chk("fl_rden_flush", 32'(rden), 32'd0);
        chk("fl_busy_flush", 32'(busy), 32'd1);
        tick(); flush = 1'b0; empty_force = 1'b1; settle();
        chk("fl_valid_after", 32'(dout.Dout_valid), 32'd0);
        chk("fl_busy_state", 32'(busy), 32'd1);
        tick(); settle();
        chk("fl_busy_idle", 32'(busy), 32'd0);
        chk("fl_valid_idle", 32'(dout.Dout_valid), 32'd0);
        tick(); empty_force = 1'b0; settle();
        chk("fl_rden_resume", 32'(rden), 32'd1);
        run(4);
        exp_q = '{8'h5A};
        compare_got("fl_order");

        // Flush while idle is harmless
        tick(); flush = 1'b1; settle();
        chk("fl_idle_busy", 32'(busy), 32'd0);
        tick(); flush = 1'b0; settle();
        chk("fl_idle_busy2", 32'(busy), 32'd0);

        // Empty toggling every cycle, consumer always ready
        got.delete();
        up_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        for (int i = 0; i < 16; i++) begin
            tick(); empty_force = (i % 2 == 0); settle();
        end
        empty_force = 1'b0;
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        compare_got("emp_order");

        // Reset mid-operation with a full skid buffer, then 17 fresh words
        got.delete();
        up_q.delete();
        for (int i = 0; i < 17; i++) up_q.push_back(8'(8'h80 + i));
        dout.Dout_ready = 1'b0;
        run(4);
        chk("mid_valid_full", 32'(dout.Dout_valid), 32'd1);
        tick(); rst = 1'b1; settle();
        chk("mid_rst_rden", 32'(rden), 32'd0);
        tick(); rst = 1'b0; up_q.delete(); dataout = 8'h00; settle();
        chk("mid_valid_lost", 32'(dout.Dout_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
`ifdef XIFO_RD_CNT_EN
        chk("mid_count", 32'(rd_count), 32'd0);
`endif
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            up_q.push_back(8'(8'hC0 + i));
            exp_q.push_back(8'(8'hC0 + i));
        end
        dout.Dout_ready = 1'b1;
        run(22);
        compare_got("wrap_order");
`ifdef XIFO_RD_CNT_EN
        chk("wrap_count", 32'(rd_count), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
